// File: rtl/cvm300_pkg.sv
// Shared types and constants for the CVM300 pixel emulator: FSM states,
// test-pattern codes, fill levels and a wrap-around window test.
package cvm300_pkg;

  localparam int PIX_W  = 10;
  localparam int COL_W  = 10;
  localparam int ROW_W  = 9;
  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FOT    = 2'd1,
    ST_LINE   = 2'd2,
    ST_HBLANK = 2'd3
  } state_t;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_BOX   = 2'd3;

  localparam logic [PIX_W-1:0] FILL_HI   = 10'h3FF;
  localparam logic [PIX_W-1:0] FILL_LO   = 10'h040;
  localparam logic [PIX_W-1:0] FILL_ZERO = 10'h000;

  // True when pos lies in [origin, origin+len) on a 1024-wide circular axis.
  function automatic logic in_window(input logic [9:0] pos,
                                     input logic [9:0] origin,
                                     input logic [10:0] len);
    logic [9:0] diff;
    diff = pos - origin;
    return ({1'b0, diff} < len);
  endfunction

endpackage

// File: rtl/cvm300_if.sv
// Sensor-side bus of the emulator: frame request/pattern in, video and status out.
interface cvm300_if;
  import cvm300_pkg::*;

  logic              frame_req;
  logic [1:0]        pattern_sel;
  logic              lval;
  logic              dval;
  logic [PIX_W-1:0]  d;
  logic              busy;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output frame_req, pattern_sel,
    input  lval, dval, d, busy, frame_cnt
  );

  modport slave (
    input  frame_req, pattern_sel,
    output lval, dval, d, busy, frame_cnt
  );

endinterface

// File: rtl/cvm300_pattern_gen.sv
// Combinational test-pattern pixel value for a given column, row, frame count
// and pattern code; the parent registers the result.
module cvm300_pattern_gen
  import cvm300_pkg::*;
#(
  parameter int BOX = 16
) (
  input  logic [COL_W-1:0] i_col,
  input  logic [ROW_W-1:0] i_row,
  input  logic [7:0]       i_frame_cnt,
  input  logic [1:0]       i_pattern,
  output logic [PIX_W-1:0] o_pixel
);

  localparam logic [10:0] BOX_LEN = (BOX >= 1024) ? 11'd1024 : 11'(BOX);

  logic [9:0] w_x0;
  logic [9:0] w_y0;
  logic       w_in_box;

  // Box origin drifts with the frame counter so consecutive frames move it.
  assign w_x0     = {i_frame_cnt[6:0], 2'b00};
  assign w_y0     = {i_frame_cnt[7:0], 1'b0};
  assign w_in_box = in_window(i_col, w_x0, BOX_LEN) &&
                    in_window({1'b0, i_row}, w_y0, BOX_LEN);

  always_comb begin
    o_pixel = FILL_ZERO;
    case (i_pattern)
      PAT_HRAMP: o_pixel = i_col;
      PAT_VRAMP: o_pixel = {1'b0, i_row};
      PAT_CHECK: o_pixel = (i_col[3] ^ i_row[3]) ? FILL_HI : FILL_ZERO;
      PAT_BOX:   o_pixel = w_in_box ? FILL_HI : FILL_LO;
      default:   o_pixel = FILL_ZERO;
    endcase
  end

endmodule

// File: rtl/cvm300_pixel_emulator.sv
// CVM300 sensor emulator: on request, waits the frame-overhead time and then
// streams V_LINES lines of H_PIXELS test-pattern pixels with blanking gaps.
module cvm300_pixel_emulator
  import cvm300_pkg::*;
#(
  parameter int H_PIXELS   = 648,
  parameter int V_LINES    = 488,
  parameter int H_BLANK    = 16,
  parameter int FOT_CYCLES = 32,
  parameter int BOX        = 16
) (
  input logic     clk,
  input logic     rst_n,
  cvm300_if.slave io_bus
);

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(H_PIXELS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(V_LINES - 1);
  localparam logic [7:0]       BLANK_LAST = 8'(H_BLANK - 1);
  localparam logic [7:0]       FOT_LAST   = 8'(FOT_CYCLES);

  state_t              r_state;
  logic [7:0]          r_fot_cnt;
  logic [7:0]          r_blank_cnt;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [1:0]          r_pat;
  logic                r_pending;
  logic                r_lval;
  logic                r_dval;
  logic [PIX_W-1:0]    r_d;
  logic                r_busy;
  logic [FCNT_W-1:0]   r_frame_cnt;

  logic [COL_W-1:0]    w_pg_col;
  logic [ROW_W-1:0]    w_pg_row;
  logic [PIX_W-1:0]    w_pixel;

  // Coordinates of the pixel that will be presented after the coming edge.
  assign w_pg_col = (r_state == ST_LINE)   ? (r_col + 10'd1) : 10'd0;
  assign w_pg_row = (r_state == ST_HBLANK) ? (r_row + 9'd1)  : r_row;

  cvm300_pattern_gen #(
    .BOX (BOX)
  ) u_pattern_gen (
    .i_col       (w_pg_col),
    .i_row       (w_pg_row),
    .i_frame_cnt (r_frame_cnt[7:0]),
    .i_pattern   (r_pat),
    .o_pixel     (w_pixel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fot_cnt   <= 8'd0;
      r_blank_cnt <= 8'd0;
      r_col       <= 10'd0;
      r_row       <= 9'd0;
      r_pat       <= 2'd0;
      r_pending   <= 1'b0;
      r_lval      <= 1'b0;
      r_dval      <= 1'b0;
      r_d         <= FILL_ZERO;
      r_busy      <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      // A request while a frame is running is remembered once; extras are dropped.
      if ((r_state != ST_IDLE) && io_bus.frame_req) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
      case (r_state)
        ST_IDLE: begin
          r_lval <= 1'b0;
          r_dval <= 1'b0;
          r_d    <= FILL_ZERO;
          if (io_bus.frame_req || r_pending) begin
            r_state   <= ST_FOT;
            r_pat     <= io_bus.pattern_sel;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
            r_fot_cnt <= 8'd0;
            r_col     <= 10'd0;
            r_row     <= 9'd0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_FOT: begin
          if (r_fot_cnt == FOT_LAST) begin
            r_state <= ST_LINE;
            r_col   <= w_pg_col;
            r_row   <= w_pg_row;
            r_lval  <= 1'b1;
            r_dval  <= 1'b1;
            r_d     <= w_pixel;
          end else begin
            r_fot_cnt <= r_fot_cnt + 8'd1;
          end
        end
        ST_LINE: begin
          if (r_col == COL_LAST) begin
            r_state     <= ST_HBLANK;
            r_blank_cnt <= 8'd0;
            r_lval      <= 1'b0;
            r_dval      <= 1'b0;
            r_d         <= FILL_ZERO;
          end else begin
            r_col <= w_pg_col;
            r_d   <= w_pixel;
          end
        end
        ST_HBLANK: begin
          if (r_blank_cnt != BLANK_LAST) begin
            r_blank_cnt <= r_blank_cnt + 8'd1;
          end else if (r_row == ROW_LAST) begin
            // Frame done: busy drops and the count advances on the same edge.
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_col       <= 10'd0;
            r_row       <= 9'd0;
          end else begin
            r_state <= ST_LINE;
            r_col   <= w_pg_col;
            r_row   <= w_pg_row;
            r_lval  <= 1'b1;
            r_dval  <= 1'b1;
            r_d     <= w_pixel;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_lval  <= 1'b0;
          r_dval  <= 1'b0;
          r_d     <= FILL_ZERO;
        end
      endcase
    end
  end

  assign io_bus.lval      = r_lval;
  assign io_bus.dval      = r_dval;
  assign io_bus.d         = r_d;
  assign io_bus.busy      = r_busy;
  assign io_bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cvm300_pixel_emulator.sv
// Directed/randomized bench for cvm300_pixel_emulator with a timeline model
// of each frame computed from cycle offsets after the accepting edge.
module tb_cvm300_pixel_emulator;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int HB   = 2;
  localparam int FOT  = 3;
  localparam int BOX  = 2;
  localparam int FLEN = FOT + 1 + V * (H + HB);

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;

  cvm300_if bus ();

  cvm300_pixel_emulator #(
    .H_PIXELS   (H),
    .V_LINES    (V),
    .H_BLANK    (HB),
    .FOT_CYCLES (FOT),
    .BOX        (BOX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [28:0] obs();
    return {bus.lval, bus.dval, bus.d, bus.busy, bus.frame_cnt};
  endfunction

  function automatic int wrap1024(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  // Pixel value straight from the pattern rules, in plain integer arithmetic.
  function automatic logic [9:0] ref_pix(input int pat, input int col, input int row, input int fc);
    int x0;
    int y0;
    int v;
    case (pat)
      0: v = col % 1024;
      1: v = row % 512;
      2: v = (((col / 8) % 2) != ((row / 8) % 2)) ? 1023 : 0;
      default: begin
        x0 = (fc % 128) * 4;
        y0 = (fc % 256) * 2;
        v  = ((wrap1024(col - x0) < BOX) && (wrap1024(row - y0) < BOX)) ? 1023 : 64;
      end
    endcase
    return 10'(v);
  endfunction

  // Expected {lval,dval,d,busy,frame_cnt} t edges after the accepting edge.
  function automatic logic [28:0] exp_vec(input int t, input int pat, input int fc0);
    int u;
    int line;
    int pos;
    logic l;
    logic [9:0] dd;
    logic b;
    logic [15:0] fc;
    l  = 1'b0;
    dd = 10'd0;
    b  = 1'b1;
    fc = 16'(fc0);
    if (t >= FLEN) begin
      b  = 1'b0;
      fc = 16'(fc0 + 1);
    end else if (t > FOT) begin
      u    = t - FOT - 1;
      line = u / (H + HB);
      pos  = u % (H + HB);
      if (pos < H) begin
        l  = 1'b1;
        dd = ref_pix(pat, pos, line, fc0);
      end
    end
    return {l, l, dd, b, fc};
  endfunction

  task automatic chk(input string tag, input int t, input logic [28:0] o, input logic [28:0] e);
    n_vec++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed={lval,dval,d,busy,fcnt}=%h expected=%h", tag, t, o, e);
    end
  endtask

  // mode 0: no further requests, 1: request held high, 2: two one-cycle pulses mid-frame.
  task automatic run_frame(input string tag, input int pat, input int fc0, input int mode,
                           input logic req_at_accept, input int stop_t);
    bus.frame_req   = req_at_accept;
    bus.pattern_sel = 2'(pat);
    tick();
    chk(tag, 0, obs(), exp_vec(0, pat, fc0));
    for (int t = 1; t <= stop_t; t++) begin
      bus.pattern_sel = 2'($urandom);
      case (mode)
        1:       bus.frame_req = 1'b1;
        2:       bus.frame_req = (t == 10) || (t == 25);
        default: bus.frame_req = 1'b0;
      endcase
      tick();
      chk(tag, t, obs(), exp_vec(t, pat, fc0));
    end
  endtask

  task automatic idle_check(input string tag, input int n, input int fc);
    for (int i = 0; i < n; i++) begin
      bus.frame_req = 1'b0;
      tick();
      chk(tag, i, obs(), {13'd0, 16'(fc)});
    end
  endtask

  initial begin
    int p;
    int fc;
    n_vec           = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.frame_req   = 1'b0;
    bus.pattern_sel = 2'd0;
    #1;
    tick();
    tick();
    chk("reset", 0, obs(), 29'd0);
    rst_n = 1'b1;

    run_frame("hramp", 0, 0, 0, 1'b1, FLEN);
    idle_check("idle_a", 3, 1);
    run_frame("box_fc1", 3, 1, 0, 1'b1, FLEN);
    run_frame("vramp_pulses", 1, 2, 2, 1'b1, FLEN);
    p = int'($urandom_range(3, 0));
    run_frame("pending_frame", p, 3, 0, 1'b0, FLEN);
    idle_check("idle_b", 4, 4);

    run_frame("hold1", int'($urandom_range(3, 0)), 4, 1, 1'b1, FLEN);
    run_frame("hold2", int'($urandom_range(3, 0)), 5, 1, 1'b1, FLEN);
    run_frame("hold3", int'($urandom_range(3, 0)), 6, 0, 1'b1, FLEN);
    idle_check("idle_c", 2, 7);

    fc = 7;
    for (int k = 0; k < 4; k++) begin
      run_frame("random", int'($urandom_range(3, 0)), fc, 0, 1'b1, FLEN);
      fc++;
      idle_check("idle_r", int'($urandom_range(3, 1)), fc);
    end

    run_frame("abort", int'($urandom_range(3, 0)), fc, 0, 1'b1, FOT + 1 + 2 * (H + HB) + 3);
    rst_n         = 1'b0;
    bus.frame_req = 1'b1;
    tick();
    chk("reset_mid", 0, obs(), 29'd0);
    rst_n = 1'b1;
    run_frame("after_reset", 0, 0, 0, 1'b1, FLEN);
    idle_check("idle_d", 2, 1);

    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    idle_check("preload", 1, 65535);
    run_frame("wrap", 3, 65535, 0, 1'b1, FLEN);
    idle_check("idle_e", 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cvm300_pixel_emulator.md
CVM300_PIXEL_EMULATOR -- requirements
Module: cvm300_pixel_emulator

Interface
REQ-001 Parameter H_PIXELS, default 648, meaning active pixels per line, range 2..1023.
REQ-002 Parameter V_LINES, default 488, meaning lines per frame, range 1..511.
REQ-003 Parameter H_BLANK, default 16, meaning idle cycles between lines, range 1..255.
REQ-004 Parameter FOT_CYCLES, default 32, meaning frame-overhead delay after request, range 1..255.
REQ-005 Parameter BOX, default 16, meaning moving-box edge length in pixels.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 frame_req  in  1  frame request, level sampled each edge.
REQ-009 pattern_sel  in  2  test pattern select.
REQ-010 lval  out  1  line valid.
REQ-011 dval  out  1  data valid.
REQ-012 d  out  10  pixel data.
REQ-013 busy  out  1  high from request acceptance to last blank cycle of the final line.
REQ-014 frame_cnt  out  16  completed frames, wraps 16'hFFFF to 0.

Function
REQ-015 FSM states IDLE, FOT, LINE, HBLANK; all outputs registered.
REQ-016 IDLE: frame_req=1 (or pending=1) -> FOT, latch pattern_sel, busy=1, clear pending.
REQ-017 FOT: hold FOT_CYCLES cycles, then LINE; first lval=1 cycle begins exactly FOT_CYCLES+1 clocks after the accepting edge.
REQ-018 LINE: lval=dval=1 for exactly H_PIXELS consecutive cycles, col 0..H_PIXELS-1, then HBLANK.
REQ-019 HBLANK: lval=dval=0, d=0 for exactly H_BLANK cycles; then row+1 and LINE, or, after row V_LINES-1, IDLE with frame_cnt+1 and busy=0.
REQ-020 Outside LINE, d=0; dval never high while lval low.
REQ-021 Pattern 0: d = col[9:0]; pattern 1: d = {1'b0,row[8:0]}; pattern 2: d = (col[3]^row[3]) ? 10'h3FF : 10'h000.
REQ-022 Pattern 3: box origin x0={frame_cnt[6:0],2'b00}, y0={frame_cnt[7:0],1'b0} (both 10-bit); d=10'h3FF when (col-x0) mod 1024 < BOX and (row-y0) mod 1024 < BOX, else 10'h040.
REQ-023 pattern_sel changes after acceptance have no effect until next frame.
REQ-024 frame_req=1 while busy sets one-deep pending flag; further requests while pending are dropped.
REQ-025 Pending frame starts on the edge IDLE is entered+1 (one IDLE cycle minimum between frames).
REQ-026 frame_req held high continuously yields back-to-back frames separated by one IDLE cycle.
REQ-027 frame_cnt increments on the same edge busy falls.

Reset
REQ-028 rst_n=0 on an edge: state IDLE, lval=dval=0, d=0, busy=0, frame_cnt=0, pending=0, row=col=0, latched pattern=0.
REQ-029 Reset mid-frame aborts immediately; no partial frame counted; frame_req sampled only from first edge with rst_n=1.

Structure
REQ-030 Shared package cvm300_pkg holds FSM state enumeration, pattern codes (PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_BOX) and fill constants 10'h3FF, 10'h040.
REQ-031 One sub-module cvm300_pattern_gen: combinational pixel value from col, row, frame_cnt, pattern; registered in parent.

Verification (H_PIXELS=8, V_LINES=4, H_BLANK=2, FOT_CYCLES=3, BOX=2)
REQ-032 One-cycle frame_req, pattern 0 -> lval high 4 cycles later, 4 bursts of 8 with d=0..7, 2-cycle gaps, busy falls, frame_cnt=1.
REQ-033 Pattern 1 -> line n carries d=n for all 8 pixels; pattern_sel changed to 2 mid-frame has no effect.
REQ-034 frame_req pulsed twice during a frame -> exactly one extra frame after one IDLE cycle; frame_cnt=2.
REQ-035 rst_n low during line 2 -> next edge all outputs 0, frame_cnt=0; new request yields full clean frame.
REQ-036 Pattern 3, frame_cnt=1 -> x0=4, y0=2; rows 2..3 cols 4..5 d=10'h3FF, all others 10'h040.
REQ-037 frame_cnt preloaded to 16'hFFFF via forced frames -> next completion gives 0.
